// File: rtl/arriskv_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants and the decoded
// operation/format enums handed from decode to the ALU.
package arriskv_pkg;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // INSTR_ADDI / TYPE_R are the zero encodings and double as the reset/illegal default
   typedef enum logic [4:0] {
      INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
      INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
      INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU, INSTR_XOR,
      INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
      INSTR_LUI, INSTR_AUIPC
   } instr_t;

   typedef enum logic [1:0] {
      TYPE_R, TYPE_I, TYPE_U
   } instr_type_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I word decoder for the OP, OP-IMM, LUI and AUIPC
// groups; anything else is flagged illegal with all side-effect flags cleared.
module instr_decoder
   import arriskv_pkg::*;
#(
   parameter int wd_regs_p = 32
) (
   input  logic [31:0]          i_word,
   output instr_t               o_instr,
   output instr_type_t          o_type,
   output logic [4:0]           o_rd,
   output logic                 o_rs1_used,
   output logic                 o_rs2_used,
   output logic                 o_writes_rd,
   output logic                 o_illegal,
   output logic [wd_regs_p-1:0] o_imm
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = i_word[6:0];
   assign funct3 = i_word[14:12];
   assign funct7 = i_word[31:25];
   assign o_rd   = i_word[11:7];

   always_comb begin
      o_instr     = INSTR_ADDI;
      o_type      = TYPE_R;
      o_rs1_used  = 1'b0;
      o_rs2_used  = 1'b0;
      o_writes_rd = 1'b0;
      o_illegal   = 1'b0;
      o_imm       = '0;
      case (opcode)
         OPC_OP_IMM: begin
            o_type      = TYPE_I;
            o_rs1_used  = 1'b1;
            o_writes_rd = 1'b1;
            o_imm       = {{(wd_regs_p-12){1'b0}}, i_word[31:20]};
            case (funct3)
               F3_ADD_SUB: o_instr = INSTR_ADDI;
               F3_SLT:     o_instr = INSTR_SLTI;
               F3_SLTU:    o_instr = INSTR_SLTIU;
               F3_XOR:     o_instr = INSTR_XORI;
               F3_OR:      o_instr = INSTR_ORI;
               F3_AND:     o_instr = INSTR_ANDI;
               F3_SLL:     if (funct7 == F7_BASE) o_instr = INSTR_SLLI;
                           else o_illegal = 1'b1;
               default:    if (funct7 == F7_BASE) o_instr = INSTR_SRLI;
                           else if (funct7 == F7_ALT) o_instr = INSTR_SRAI;
                           else o_illegal = 1'b1;
            endcase
         end
         OPC_OP: begin
            o_type      = TYPE_R;
            o_rs1_used  = 1'b1;
            o_rs2_used  = 1'b1;
            o_writes_rd = 1'b1;
            case ({funct7, funct3})
               {F7_BASE, F3_ADD_SUB}: o_instr = INSTR_ADD;
               {F7_ALT,  F3_ADD_SUB}: o_instr = INSTR_SUB;
               {F7_BASE, F3_SLL}:     o_instr = INSTR_SLL;
               {F7_BASE, F3_SLT}:     o_instr = INSTR_SLT;
               {F7_BASE, F3_SLTU}:    o_instr = INSTR_SLTU;
               {F7_BASE, F3_XOR}:     o_instr = INSTR_XOR;
               {F7_BASE, F3_SRL_SRA}: o_instr = INSTR_SRL;
               {F7_ALT,  F3_SRL_SRA}: o_instr = INSTR_SRA;
               {F7_BASE, F3_OR}:      o_instr = INSTR_OR;
               {F7_BASE, F3_AND}:     o_instr = INSTR_AND;
               default:               o_illegal = 1'b1;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            o_instr     = (opcode == OPC_LUI) ? INSTR_LUI : INSTR_AUIPC;
            o_type      = TYPE_U;
            o_writes_rd = 1'b1;
            o_imm       = {{(wd_regs_p-20){1'b0}}, i_word[31:12]};
         end
         default: o_illegal = 1'b1;
      endcase
      // an illegal word must neither stall on nor reserve any register
      if (o_illegal) begin
         o_instr     = INSTR_ADDI;
         o_type      = TYPE_R;
         o_rs1_used  = 1'b0;
         o_rs2_used  = 1'b0;
         o_writes_rd = 1'b0;
         o_imm       = '0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage feeding the ALU: busy-bit scoreboard for RAW stalls (no bypass),
// valid/ready handshake on both sides and a single output register slice.
module decode_stage
   import arriskv_pkg::*;
#(
   parameter int wd_regs_p = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [wd_regs_p-1:0] i_pc,
   input  logic [31:0]          i_instr_word,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic [4:0]           o_rs1_addr,
   output logic [4:0]           o_rs2_addr,
   input  logic [wd_regs_p-1:0] i_rs1_data,
   input  logic [wd_regs_p-1:0] i_rs2_data,
   input  logic                 i_wb_en,
   input  logic [4:0]           i_wb_rd,
   output logic                 o_valid,
   input  logic                 i_ready,
   output instr_t               o_instr,
   output instr_type_t          o_instr_type,
   output logic [wd_regs_p-1:0] o_arg1,
   output logic [wd_regs_p-1:0] o_arg2,
   output logic [4:0]           o_rd,
   output logic [wd_regs_p-1:0] o_pc,
   output logic                 o_illegal
);

   instr_t               dec_instr;
   instr_type_t          dec_type;
   logic [4:0]           dec_rd;
   logic                 dec_rs1_used, dec_rs2_used, dec_writes_rd, dec_illegal;
   logic [wd_regs_p-1:0] dec_imm;

   instr_decoder #(.wd_regs_p(wd_regs_p)) u_instr_decoder (
      .i_word      (i_instr_word),
      .o_instr     (dec_instr),
      .o_type      (dec_type),
      .o_rd        (dec_rd),
      .o_rs1_used  (dec_rs1_used),
      .o_rs2_used  (dec_rs2_used),
      .o_writes_rd (dec_writes_rd),
      .o_illegal   (dec_illegal),
      .o_imm       (dec_imm)
   );

   logic [31:0]          busy_q, busy_d;
   logic                 valid_q, valid_d, illegal_q, illegal_d;
   instr_t               instr_q, instr_d;
   instr_type_t          type_q, type_d;
   logic [wd_regs_p-1:0] arg1_q, arg1_d, arg2_q, arg2_d, pc_q, pc_d;
   logic [4:0]           rd_q, rd_d;
   logic                 hazard, accept;

   assign o_rs1_addr = i_instr_word[19:15];
   assign o_rs2_addr = i_instr_word[24:20];

   assign hazard = (dec_rs1_used && (o_rs1_addr != 5'd0) && busy_q[o_rs1_addr]) ||
                   (dec_rs2_used && (o_rs2_addr != 5'd0) && busy_q[o_rs2_addr]);
   assign o_ready = (!valid_q || i_ready) && !hazard;
   assign accept  = i_valid && o_ready;

   always_comb begin
      valid_d   = valid_q;
      illegal_d = illegal_q;
      instr_d   = instr_q;
      type_d    = type_q;
      arg1_d    = arg1_q;
      arg2_d    = arg2_q;
      rd_d      = rd_q;
      pc_d      = pc_q;
      if (accept) begin
         valid_d   = 1'b1;
         illegal_d = dec_illegal;
         instr_d   = dec_instr;
         type_d    = dec_type;
         arg1_d    = dec_rs1_used ? i_rs1_data : '0;
         arg2_d    = dec_rs2_used ? i_rs2_data : dec_imm;
         rd_d      = dec_rd;
         pc_d      = i_pc;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   // clear before set so a same-cycle retire and re-reserve leaves the bit busy
   always_comb begin
      busy_d = busy_q;
      if (i_wb_en) busy_d[i_wb_rd] = 1'b0;
      if (accept && dec_writes_rd && (dec_rd != 5'd0)) busy_d[dec_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         instr_q   <= INSTR_ADDI;
         type_q    <= TYPE_R;
         arg1_q    <= '0;
         arg2_q    <= '0;
         rd_q      <= '0;
         pc_q      <= '0;
      end else begin
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         instr_q   <= instr_d;
         type_q    <= type_d;
         arg1_q    <= arg1_d;
         arg2_q    <= arg2_d;
         rd_q      <= rd_d;
         pc_q      <= pc_d;
      end
   end

   assign o_valid      = valid_q;
   assign o_illegal    = illegal_q;
   assign o_instr      = instr_q;
   assign o_instr_type = type_q;
   assign o_arg1       = arg1_q;
   assign o_arg2       = arg2_q;
   assign o_rd         = rd_q;
   assign o_pc         = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, all checked
// against an encoder-table reference with a plain busy-bit array and regfile.
module tb_decode_stage;
   import arriskv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  i_pc;
   logic [31:0]   i_instr_word;
   logic          i_valid, o_ready;
   logic [4:0]    o_rs1_addr, o_rs2_addr;
   logic [W-1:0]  i_rs1_data, i_rs2_data;
   logic          i_wb_en;
   logic [4:0]    i_wb_rd;
   logic          o_valid, i_ready;
   instr_t        o_instr;
   instr_type_t   o_instr_type;
   logic [W-1:0]  o_arg1, o_arg2, o_pc;
   logic [4:0]    o_rd;
   logic          o_illegal;

   always #5 clk = ~clk;

   decode_stage #(.wd_regs_p(W)) dut (
      .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr_word(i_instr_word),
      .i_valid(i_valid), .o_ready(o_ready), .o_rs1_addr(o_rs1_addr),
      .o_rs2_addr(o_rs2_addr), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
      .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .o_valid(o_valid), .i_ready(i_ready),
      .o_instr(o_instr), .o_instr_type(o_instr_type), .o_arg1(o_arg1),
      .o_arg2(o_arg2), .o_rd(o_rd), .o_pc(o_pc), .o_illegal(o_illegal)
   );

   logic [W-1:0] rf [32];
   assign i_rs1_data = rf[o_rs1_addr];
   assign i_rs2_data = rf[o_rs2_addr];

   typedef struct {
      instr_t      ins;
      instr_type_t ty;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit          shift;
   } enc_t;

   // encoder view of the ISA: operation -> field values
   function automatic enc_t enc_of(input int k);
      enc_t e;
      case (k)
         0:  e = '{INSTR_ADDI,  TYPE_I, 7'h13, 3'd0, 7'h00, 1'b0};
         1:  e = '{INSTR_SLTI,  TYPE_I, 7'h13, 3'd2, 7'h00, 1'b0};
         2:  e = '{INSTR_SLTIU, TYPE_I, 7'h13, 3'd3, 7'h00, 1'b0};
         3:  e = '{INSTR_XORI,  TYPE_I, 7'h13, 3'd4, 7'h00, 1'b0};
         4:  e = '{INSTR_ORI,   TYPE_I, 7'h13, 3'd6, 7'h00, 1'b0};
         5:  e = '{INSTR_ANDI,  TYPE_I, 7'h13, 3'd7, 7'h00, 1'b0};
         6:  e = '{INSTR_SLLI,  TYPE_I, 7'h13, 3'd1, 7'h00, 1'b1};
         7:  e = '{INSTR_SRLI,  TYPE_I, 7'h13, 3'd5, 7'h00, 1'b1};
         8:  e = '{INSTR_SRAI,  TYPE_I, 7'h13, 3'd5, 7'h20, 1'b1};
         9:  e = '{INSTR_ADD,   TYPE_R, 7'h33, 3'd0, 7'h00, 1'b0};
         10: e = '{INSTR_SUB,   TYPE_R, 7'h33, 3'd0, 7'h20, 1'b0};
         11: e = '{INSTR_SLL,   TYPE_R, 7'h33, 3'd1, 7'h00, 1'b0};
         12: e = '{INSTR_SLT,   TYPE_R, 7'h33, 3'd2, 7'h00, 1'b0};
         13: e = '{INSTR_SLTU,  TYPE_R, 7'h33, 3'd3, 7'h00, 1'b0};
         14: e = '{INSTR_XOR,   TYPE_R, 7'h33, 3'd4, 7'h00, 1'b0};
         15: e = '{INSTR_SRL,   TYPE_R, 7'h33, 3'd5, 7'h00, 1'b0};
         16: e = '{INSTR_SRA,   TYPE_R, 7'h33, 3'd5, 7'h20, 1'b0};
         17: e = '{INSTR_OR,    TYPE_R, 7'h33, 3'd6, 7'h00, 1'b0};
         18: e = '{INSTR_AND,   TYPE_R, 7'h33, 3'd7, 7'h00, 1'b0};
         19: e = '{INSTR_LUI,   TYPE_U, 7'h37, 3'd0, 7'h00, 1'b0};
         default: e = '{INSTR_AUIPC, TYPE_U, 7'h17, 3'd0, 7'h00, 1'b0};
      endcase
      return e;
   endfunction

   function automatic logic [31:0] enc_word(input int k, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm);
      enc_t e;
      e = enc_of(k);
      if (e.ty == TYPE_U) return {imm, rd, e.opc};
      if (e.ty == TYPE_R) return {e.f7, rs2, rs1, e.f3, rd, e.opc};
      if (e.shift)        return {e.f7, imm[4:0], rs1, e.f3, rd, e.opc};
      return {imm[11:0], rs1, e.f3, rd, e.opc};
   endfunction

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference state
   bit           m_busy [32];
   logic         m_valid, m_illegal;
   instr_t       m_instr;
   instr_type_t  m_type;
   logic [W-1:0] m_arg1, m_arg2, m_pc;
   logic [4:0]   m_rd;
   int           cur_k;     // -1 means the presented word is illegal
   bit           last_acc;

   task automatic drive(input logic [31:0] w, input int k, input logic v,
                        input logic rdy, input logic wbe, input logic [4:0] wbr);
      i_instr_word = w;
      cur_k        = k;
      i_valid      = v;
      i_ready      = rdy;
      i_wb_en      = wbe;
      i_wb_rd      = wbr;
      i_pc         = $urandom;
   endtask

   task automatic tick();
      enc_t         e;
      logic [4:0]   rs1, rs2, rdf;
      bit           hz, exp_rdy, acc;
      logic [W-1:0] a1, a2;
      #1;
      rs1 = i_instr_word[19:15];
      rs2 = i_instr_word[24:20];
      rdf = i_instr_word[11:7];
      e   = enc_of(cur_k < 0 ? 0 : cur_k);
      hz  = 1'b0;
      if (cur_k >= 0 && e.ty != TYPE_U && rs1 != 0 && m_busy[rs1]) hz = 1'b1;
      if (cur_k >= 0 && e.ty == TYPE_R && rs2 != 0 && m_busy[rs2]) hz = 1'b1;
      exp_rdy = (!m_valid || i_ready) && !hz;
      chk("o_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
      chk("rs1_addr", {27'd0, o_rs1_addr}, {27'd0, rs1});
      acc = i_valid && exp_rdy;
      a1  = (e.ty == TYPE_U) ? '0 : rf[rs1];
      a2  = (e.ty == TYPE_R) ? rf[rs2] :
            (e.ty == TYPE_I) ? {20'd0, i_instr_word[31:20]} : {12'd0, i_instr_word[31:12]};
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_valid = 0; m_illegal = 0; m_instr = INSTR_ADDI; m_type = TYPE_R;
         m_arg1 = '0; m_arg2 = '0; m_rd = '0; m_pc = '0;
         acc = 1'b0;
      end else begin
         if (i_wb_en) m_busy[i_wb_rd] = 1'b0;
         if (acc) begin
            m_valid   = 1'b1;
            m_illegal = (cur_k < 0);
            m_instr   = (cur_k < 0) ? INSTR_ADDI : e.ins;
            m_type    = e.ty;
            m_arg1    = a1;
            m_arg2    = a2;
            m_rd      = rdf;
            m_pc      = i_pc;
            if (cur_k >= 0 && rdf != 0) m_busy[rdf] = 1'b1;
         end else if (i_ready) begin
            m_valid = 1'b0;
         end
      end
      last_acc = acc;
      #1;
      chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
      chk("o_illegal", {31'd0, o_illegal}, {31'd0, m_illegal});
      chk("o_instr", 32'(o_instr), 32'(m_instr));
      chk("o_pc", o_pc, m_pc);
      if (!m_illegal) begin
         chk("o_instr_type", 32'(o_instr_type), 32'(m_type));
         chk("o_arg1", o_arg1, m_arg1);
         chk("o_arg2", o_arg2, m_arg2);
         chk("o_rd", {27'd0, o_rd}, {27'd0, m_rd});
      end
      // writeback result lands in the regfile after the edge that retires it
      if (i_wb_en && i_wb_rd != 0 && !rst) rf[i_wb_rd] = $urandom;
   endtask

   logic [31:0] w_add, rnd;
   int k;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : $urandom;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_valid = 0; m_illegal = 0; m_instr = INSTR_ADDI; m_type = TYPE_R;
      m_arg1 = '0; m_arg2 = '0; m_rd = '0; m_pc = '0;
      rst = 1'b1;
      drive(32'h0, 0, 1'b0, 1'b1, 1'b0, 5'd0);
      tick();
      tick();
      chk("reset_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_arg2", o_arg2, 32'd0);
      rst = 1'b0;

      // ADDI x1,x0,5 then dependent ADD x2,x1,x1
      drive(32'h00500093, 0, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      chk("addi_instr", 32'(o_instr), 32'(INSTR_ADDI));
      chk("addi_arg2", o_arg2, 32'h5);
      chk("addi_rd", {27'd0, o_rd}, 32'd1);
      drive(32'h00108133, 9, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      chk("add_stall", {31'd0, last_acc}, 32'd0);
      tick();
      i_wb_en = 1'b1; i_wb_rd = 5'd1;
      tick();
      i_wb_en = 1'b0;
      tick();
      chk("add_after_wb", {31'd0, last_acc}, 32'd1);
      chk("add_instr", 32'(o_instr), 32'(INSTR_ADD));
      chk("add_type", 32'(o_instr_type), 32'(TYPE_R));

      // LUI ignores a busy x1
      drive(32'h00500093, 0, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      drive(32'h123451B7, 19, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      chk("lui_instr", 32'(o_instr), 32'(INSTR_LUI));
      chk("lui_arg2", o_arg2, 32'h00012345);
      chk("lui_arg1", o_arg1, 32'h0);

      // SRAI then three cycles of backpressure
      drive(32'h40325213, 8, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      chk("srai_instr", 32'(o_instr), 32'(INSTR_SRAI));
      chk("srai_arg2", o_arg2, 32'h403);
      for (int i = 0; i < 3; i++) begin
         drive(enc_word(3, 5'd7, 5'd0, 5'd0, 20'h00abc), 3, 1'b1, 1'b0, 1'b0, 5'd0);
         tick();
         chk("bp_hold", 32'(o_instr), 32'(INSTR_SRAI));
      end

      // illegal single beat, then same-cycle set/clear on x5
      drive(32'h0000007F, -1, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      chk("illegal_flag", {31'd0, o_illegal}, 32'd1);
      drive(32'h00500293, 0, 1'b1, 1'b1, 1'b1, 5'd5);
      tick();
      w_add = enc_word(9, 5'd6, 5'd5, 5'd0, 20'd0);
      drive(w_add, 9, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      chk("x5_set_wins", {31'd0, last_acc}, 32'd0);
      drive(w_add, 9, 1'b1, 1'b1, 1'b1, 5'd5);
      tick();
      i_wb_en = 1'b0;
      tick();

      // reset in the middle of a stall
      drive(32'h00500093, 0, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      drive(32'h00108133, 9, 1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("rst_stall_valid", {31'd0, o_valid}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_reaccept", {31'd0, last_acc}, 32'd1);

      // random traffic; a rejected instruction stays presented
      last_acc = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if (!(i_valid && !last_acc)) begin
            rnd = $urandom;
            if (rnd[3:0] == 4'd0) begin
               k = -1;
               case (rnd[5:4])
                  2'd0: w_add = {rnd[31:7], 7'h7F};
                  2'd1: w_add = {7'h01, rnd[24:7], 7'h33};
                  2'd2: w_add = {7'h20, rnd[24:15], 3'd1, rnd[11:7], 7'h13};
                  default: w_add = {rnd[31:7], 7'h03};
               endcase
            end else begin
               k = $urandom_range(0, 20);
               w_add = enc_word(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                5'($urandom_range(0, 7)), 20'($urandom));
            end
            i_instr_word = w_add;
            cur_k = k;
            i_valid = ($urandom_range(0, 3) != 0);
         end
         i_ready = ($urandom_range(0, 3) != 0);
         i_pc    = $urandom;
         i_wb_en = ($urandom_range(0, 2) == 0);
         i_wb_rd = 5'($urandom_range(0, 31));
         begin
            int s;
            s = $urandom_range(0, 31);
            for (int j = 0; j < 32; j++)
               if (m_busy[(s + j) % 32]) begin
                  i_wb_rd = 5'((s + j) % 32);
                  break;
               end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
